// File: rtl/alu_pkg.sv
// Shared types for the round-robin ALU scheduler: ALU operation codes and scheduler FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// Per-requester response FIFO: one push and one pop per cycle, head served from the storage register.
module alu_resp_fifo
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // Pop on an empty FIFO is ignored.
    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Credits upstream guarantee a full FIFO is never pushed without a simultaneous pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one pipelined add/sub ALU between NUM_REQ requesters,
// with a tag pipe routing results into credit-gated per-requester response FIFOs.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 6,
    parameter int ALU_LAT    = 2,
    parameter int RESP_DEPTH = 4
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    output logic                            idle,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][1:0]         req_op,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [NUM_REQ-1:0][WIDTH-1:0]   resp_data,
    output operation_t                      alu_op,
    output logic [WIDTH-1:0]                alu_a,
    output logic [WIDTH-1:0]                alu_b,
    output logic                            alu_in_valid,
    input  logic [WIDTH-1:0]                alu_out,
    input  logic                            alu_out_valid,
    output logic                            err_orphan
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    sched_state_t       r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_credit [NUM_REQ];
    logic [ALU_LAT-1:0] r_tag_vld;
    logic [IW-1:0]      r_tag_idx [ALU_LAT];
    logic               r_err;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [IW-1:0]      w_gidx;
    logic               w_any;
    logic               w_pipe_empty;

    // A request transfers when req_valid[i] and req_ready[i] are both high in the same cycle;
    // ready is computed from valid, so requesters must raise valid without waiting for ready.
    always_comb begin : p_arb
        int j;
        j       = 0;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_valid[i] && (r_credit[i] != '0);
        end
        if ((r_state == ST_RUN) && en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                j = (int'(r_rr_ptr) + k) % NUM_REQ;
                if (!w_any && w_elig[j]) begin
                    w_any      = 1'b1;
                    w_gidx     = IW'(j);
                    w_grant[j] = 1'b1;
                end
            end
        end
    end

    assign req_ready    = w_grant;
    assign alu_in_valid = w_any;
    assign alu_op       = w_any ? operation_t'(req_op[w_gidx]) : OP_NOP;
    assign alu_a        = w_any ? req_a[w_gidx] : '0;
    assign alu_b        = w_any ? req_b[w_gidx] : '0;
    assign idle         = (r_state == ST_HALT);
    assign err_orphan   = r_err;
    assign w_pipe_empty = (r_tag_vld == '0) && !alu_out_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
        assign w_push[g] = alu_out_valid && r_tag_vld[ALU_LAT-1] && (r_tag_idx[ALU_LAT-1] == IW'(g));
        assign w_pop[g]  = resp_valid[g] && resp_ready[g];

        alu_resp_fifo #(.WIDTH(WIDTH), .DEPTH(RESP_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[g]),
            .i_data  (alu_out),
            .i_pop   (resp_ready[g]),
            .o_valid (resp_valid[g]),
            .o_data  (resp_data[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HALT;
            r_rr_ptr <= IW'(NUM_REQ - 1);
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_credit[i] <= CW'(RESP_DEPTH);
            end
            r_tag_vld <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                r_tag_idx[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_HALT:  if (en) r_state <= ST_RUN;
                ST_RUN:   if (!en) r_state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (en)                r_state <= ST_RUN;
                    else if (w_pipe_empty) r_state <= ST_HALT;
                end
                default:  r_state <= ST_HALT;
            endcase

            if (w_any) begin
                r_rr_ptr <= w_gidx;
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                case ({w_grant[i], w_pop[i]})
                    2'b10:   r_credit[i] <= r_credit[i] - CW'(1);
                    2'b01:   r_credit[i] <= r_credit[i] + CW'(1);
                    default: r_credit[i] <= r_credit[i];
                endcase
            end

            // Stage 0 tracks the request entering the ALU; the last stage matches alu_out_valid.
            r_tag_vld[0] <= w_any;
            r_tag_idx[0] <= w_gidx;
            for (int k = 1; k < ALU_LAT; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_idx[k] <= r_tag_idx[k-1];
            end

            if (alu_out_valid && !r_tag_vld[ALU_LAT-1]) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched paired with a 2-cycle add/sub ALU model and a queue-based response model.
module tb_alu_rr_sched;
    import alu_pkg::*;

    localparam int N = 4;
    localparam int W = 6;
    localparam int D = 4;
    localparam int RESP_LAT = 3;

    typedef struct {
        int          idx;
        logic [W-1:0] data;
        int          due;
    } pend_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 idle;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][1:0]    req_op = '0;
    logic [N-1:0][W-1:0]  req_a = '0;
    logic [N-1:0][W-1:0]  req_b = '0;
    logic [N-1:0]         resp_valid;
    logic [N-1:0]         resp_ready = '0;
    logic [N-1:0][W-1:0]  resp_data;
    operation_t           alu_op;
    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic                 alu_in_valid;
    logic [W-1:0]         alu_out;
    logic                 alu_out_valid;
    logic                 err_orphan;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    bit m_run = 1'b0;
    int m_last = N - 1;
    logic [W-1:0] exp_q [N][$];
    pend_t pend_q[$];

    alu_rr_sched #(.NUM_REQ(N), .WIDTH(W), .ALU_LAT(2), .RESP_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .idle(idle),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
        .alu_out(alu_out), .alu_out_valid(alu_out_valid), .err_orphan(err_orphan)
    );

    // ---------------- clock / reset-free ALU model ----------------
    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_v1 = 1'b0, a_v2 = 1'b0;
    logic [1:0]   a_op1 = '0;
    logic [W-1:0] a_a1 = '0, a_b1 = '0, a_r2 = '0;
    always @(posedge clk) begin
        a_v1  <= alu_in_valid;
        a_op1 <= alu_op;
        a_a1  <= alu_a;
        a_b1  <= alu_b;
        a_v2  <= a_v1;
        case (a_op1)
            2'd1:    a_r2 <= a_a1 + a_b1;
            2'd2:    a_r2 <= a_a1 - a_b1;
            default: a_r2 <= '0;
        endcase
    end
    assign alu_out       = a_r2;
    assign alu_out_valid = a_v2;

    // ---------------- scoreboard helpers ----------------
    function automatic logic [W-1:0] calc(int op, int a, int b);
        int m;
        m = 1 << W;
        if (op == 1) return W'((a + b) % m);
        if (op == 2) return W'((a - b + m) % m);
        return '0;
    endfunction

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            int outst [N];
            int eg;
            logic [N-1:0] exp_grant;
            pend_t p;
            while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                exp_q[p.idx].push_back(p.data);
            end
            for (int i = 0; i < N; i++) begin
                check("resp_valid", int'(resp_valid[i]), int'(exp_q[i].size() != 0));
                if (resp_valid[i] && exp_q[i].size() != 0)
                    check("resp_data", int'(resp_data[i]), int'(exp_q[i][0]));
                outst[i] = exp_q[i].size();
            end
            foreach (pend_q[k]) outst[pend_q[k].idx]++;
            eg = -1;
            if (en && m_run) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (eg < 0 && req_valid[j] && outst[j] < D) eg = j;
                end
            end
            exp_grant = '0;
            if (eg >= 0) exp_grant[eg] = 1'b1;
            check("grant", int'(req_ready), int'(exp_grant));
            check("alu_in_valid", int'(alu_in_valid), int'(eg >= 0));
            check("alu_op", int'(alu_op), (eg >= 0) ? int'(req_op[eg]) : 0);
            check("alu_a", int'(alu_a), (eg >= 0) ? int'(req_a[eg]) : 0);
            check("alu_b", int'(alu_b), (eg >= 0) ? int'(req_b[eg]) : 0);
            check("err_orphan", int'(err_orphan), 0);
            if (eg >= 0) begin
                p.idx  = eg;
                p.data = calc(int'(req_op[eg]), int'(req_a[eg]), int'(req_b[eg]));
                p.due  = cyc + RESP_LAT;
                pend_q.push_back(p);
                m_last = eg;
            end
            for (int i = 0; i < N; i++) begin
                if (resp_ready[i] && exp_q[i].size() != 0) void'(exp_q[i].pop_front());
            end
            m_run = en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_single(int idx, int op, int a, int b, int expv, string nm);
        int lat;
        bit got;
        req_valid[idx] = 1'b1;
        req_op[idx]    = 2'(op);
        req_a[idx]     = W'(a);
        req_b[idx]     = W'(b);
        @(negedge clk);
        check({nm, "_ready"}, int'(req_ready), 1 << idx);
        step();
        req_valid[idx] = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            if (resp_valid[idx]) got = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        check({nm, "_latency"}, lat, RESP_LAT);
        check({nm, "_data"}, int'(resp_data[idx]), expv);
        step();
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            req_op[i] = 2'($urandom_range(0, 2));
            req_a[i]  = W'($urandom);
            req_b[i]  = W'($urandom);
        end
    endtask

    task automatic settle(int n);
        req_valid  = '0;
        resp_ready = '1;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int cnt, prev, cur, waited;
        bit seen;

        @(negedge clk);
        check("rst_idle", int'(idle), 1);
        check("rst_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_alu_in_valid", int'(alu_in_valid), 0);
        check("rst_err", int'(err_orphan), 0);
        step();
        step();
        rst_n = 1'b1;
        resp_ready = '1;
        chk_on = 1'b1;
        step();
        @(negedge clk);
        check("halt_idle", int'(idle), 1);
        en = 1'b1;
        step();
        step();

        // single op and wrap-around arithmetic
        do_single(0, 1, 5, 7, 12, "single");
        do_single(1, 2, 3, 5, 62, "wrap_sub");
        do_single(1, 1, 40, 30, 6, "wrap_add");
        do_single(1, 2, 0, 0, 0, "sub_zero");
        settle(6);

        // fairness: all requesters always valid
        req_valid = '1;
        prev = -1;
        for (int c = 0; c < 16; c++) begin
            randomize_ops();
            @(negedge clk);
            check("fair_onehot", $countones(req_ready), 1);
            cur = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) cur = i;
            if (prev >= 0) check("fair_order", cur, (prev + 1) % N);
            prev = cur;
            step();
        end
        settle(8);

        // backpressure on requester 2
        resp_ready[2] = 1'b0;
        req_valid     = 4'b0100;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            randomize_ops();
            @(negedge clk);
            cnt += int'(req_ready[2]);
            step();
        end
        check("bp_grants", cnt, D);
        resp_ready[2] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cnt += int'(req_ready[2]);
            step();
            resp_ready[2] = 1'b0;
        end
        check("bp_one_more", cnt, 1);
        settle(10);

        // drain: drop en mid-burst on three requesters
        req_valid = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            randomize_ops();
            step();
        end
        en = 1'b0;
        @(negedge clk);
        check("drain_nogrant", int'(req_ready), 0);
        check("drain_not_idle", int'(idle), 0);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 12) begin
            step();
            waited++;
            @(negedge clk);
            if (idle) seen = 1'b1;
        end
        check("drain_idle_seen", int'(seen), 1);
        check("drain_delivered", pend_q.size(), 0);
        settle(3);
        en = 1'b1;
        step();
        step();

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            randomize_ops();
            resp_ready = N'($urandom);
            en = ($urandom_range(0, 19) != 0);
            step();
        end
        en = 1'b1;
        settle(12);

        // reset with two operations still inside the ALU
        req_valid = 4'b0011;
        req_op[0] = 2'd1;
        req_op[1] = 2'd1;
        @(negedge clk);
        check("rst6_grant_a", $countones(req_ready), 1);
        step();
        @(negedge clk);
        check("rst6_grant_b", $countones(req_ready), 1);
        step();
        req_valid = '0;
        chk_on = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst6_idle", int'(idle), 1);
        check("rst6_ready", int'(req_ready), 0);
        check("rst6_resp_valid", int'(resp_valid), 0);
        check("rst6_alu_in_valid", int'(alu_in_valid), 0);
        check("rst6_alu_op", int'(alu_op), 0);
        check("rst6_alu_ab", int'({alu_a, alu_b}), 0);
        check("rst6_err_low", int'(err_orphan), 0);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst6_err", int'(err_orphan), 1);
            check("rst6_no_resp", int'(resp_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
